ota_stim_measure: RTL and testbench
===================================

Name: ota_stim_measure

Overview:
- Stimulus/measurement engine inside the user project, directly upstream of the wrapper's io_out/io_oeb pads and downstream of its la_data_in bits.
- Drives a programmable square wave onto one GPIO to excite the OTA under test.
- Samples the OTA comparator return on another GPIO and counts high cycles and rising edges over a programmed window.
- Results are returned to the management core on la_data_out.

Parameters:
- CNT_W, 24, width of window length, high-cycle counter and window counter.
- DIV_W, 16, width of stimulus half-period.
- EDGE_W, 16, width of rising-edge counter.

Ports:
- wb_clk_i  in  1  sole clock; all LA inputs are synchronous to it.
- wb_rst_n  in  1  reset, asynchronous assert, active-low.
- start_tgl  in  1  start request; each change of level is one request.
- window  in  CNT_W  measurement length in clock cycles; sampled at start.
- half_period  in  DIV_W  stimulus half-period in cycles; sampled at start.
- cmp_in  in  1  comparator pad input (io_in), asynchronous.
- stim_out  out  1  stimulus to pad (io_out).
- stim_oeb  out  1  pad output-enable, active-low (io_oeb).
- busy  out  1  high while measuring.
- done  out  1  sticky result-valid flag.
- ovf  out  1  sticky overflow: a counter saturated during the run.
- high_count  out  CNT_W  cycles with synchronised cmp high.
- edge_count  out  EDGE_W  synchronised rising edges.

Behaviour:
- Reset values:
  - stim_out=0, stim_oeb=1, busy=0, done=0, ovf=0, high_count=0, edge_count=0.
  - FSM in IDLE; start_q=0; synchroniser flops=0.
- Start detect:
  - start_q is a register of start_tgl; start_req = start_tgl XOR start_q.
  - If start_tgl is already 1 when reset is released, the first clock produces one request.
- cmp_in passes through a 2-flop synchroniser (cmp_s) plus one history flop (cmp_d); rise = cmp_s & ~cmp_d.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start_req (request seen at the edge of cycle N):
  - Latch window into win_cnt and max(half_period,1) into hp_reg.
  - Clear high_count, edge_count, ovf and done.
  - Load div_cnt=hp_reg-1 and set stim_out=0; cmp_d is loaded with cmp_s.
  - Go to RUN: busy=1 and stim_oeb=0 from cycle N+1.
- RUN, every cycle:
  - div_cnt==0: toggle stim_out and reload hp_reg-1; otherwise decrement.
  - cmp_s==1: high_count+1, saturating at all-ones and setting ovf.
  - rise: edge_count+1, saturating and setting ovf.
  - win_cnt decrements; the cycle in which win_cnt==1 is the last counted cycle.
  - Next state DONE: busy=0, done=1, stim_oeb=1, stim_out=0.
- Window length:
  - window==0 loaded: RUN lasts exactly one cycle, counts nothing, then DONE with counts 0.
  - Otherwise exactly `window` cycles are counted.
- Counting starts with the first RUN cycle; there is no hold-off for synchroniser latency (2 cycles), which the software accounts for.
- start_req while in RUN is ignored and consumed (start_q tracks); there is no restart or abort.
- DONE: outputs are held stable until the next start_req.
- Reset asserted mid-run: all outputs go to reset values asynchronously; the run is lost.

Test Plan:
- Reset release, start_tgl=0:
  - Outputs at reset values; no request generated.
  - stim_oeb=1 held for 100 cycles.
- window=100, half_period=5, cmp_in tied 1 → busy exactly 100 cycles.
  - stim_out period is 10 cycles, with its first rise 5 cycles after RUN entry.
  - high_count=100 and edge_count=1 (the synchroniser starts at 0, so cmp_s rises during the run).
  - done=1 and ovf=0.
- window=1000, cmp_in square wave of period 20 cycles, 50% duty, asynchronous phase:
  - edge_count is 50±1 and high_count is 500±10.
  - stim_oeb returns to 1 when done asserts.
- window=0: done asserts 2 cycles after start_req with all counts 0; half_period=0 behaves as 1, so stim_out toggles every cycle.
- CNT_W overridden to 8, window=255+20 is unrepresentable, so use window=255:
  - With cmp high: high_count=255 saturated and ovf=0.
  - Repeat with EDGE_W=2 and a fast cmp toggle: edge_count=3 and ovf=1.
- Second start toggle mid-run leaves the run unaffected and produces no restart after DONE.
- wb_rst_n pulsed low mid-run:
  - Immediate return to reset values.
  - A new start afterwards completes normally.

Source files
------------

// File: rtl/ota_stim_measure.sv
// rtl/ota_stim_measure.sv - square-wave OTA stimulus and comparator high/edge measurement engine
`timescale 1ns/1ps
module ota_stim_measure #(
  parameter int CNT_W  = 24,
  parameter int DIV_W  = 16,
  parameter int EDGE_W = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              start_tgl,
  input  logic [CNT_W-1:0]  window,
  input  logic [DIV_W-1:0]  half_period,
  input  logic              cmp_in,
  output logic              stim_out,
  output logic              stim_oeb,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [CNT_W-1:0]  high_count,
  output logic [EDGE_W-1:0] edge_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               load;
  logic               start_q;
  logic               start_req;
  logic               cmp_m;
  logic               cmp_s;
  logic               cmp_d;
  logic               rise;
  logic               count_en;
  logic               last_cycle;
  logic [CNT_W-1:0]   win_cnt;
  logic [DIV_W-1:0]   hp_reg;
  logic [DIV_W-1:0]   hp_eff;
  logic [DIV_W-1:0]   div_cnt;

  // A zero half-period would stall the divider, so it is treated as one.
  assign hp_eff     = (half_period == '0) ? DIV_W'(1) : half_period;
  assign start_req  = start_tgl ^ start_q;
  assign rise       = cmp_s & ~cmp_d;
  // win_cnt==0 means a zero-length window: one RUN cycle that counts nothing.
  assign count_en   = (state == RUN) && (win_cnt != '0);
  assign last_cycle = (win_cnt == '0) || (win_cnt == CNT_W'(1));

  // Start edge detector and comparator synchroniser with history flop.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      start_q <= 1'b0;
      cmp_m   <= 1'b0;
      cmp_s   <= 1'b0;
      cmp_d   <= 1'b0;
    end else begin
      start_q <= start_tgl;
      cmp_m   <= cmp_in;
      cmp_s   <= cmp_m;
      cmp_d   <= cmp_s;
    end
  end

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status decode; requests during RUN are simply dropped.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    stim_oeb  = 1'b1;
    case (state)
      IDLE: begin
        if (start_req) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        busy     = 1'b1;
        stim_oeb = 1'b0;
        if (last_cycle) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start_req) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stimulus divider, window countdown and saturating measurement counters.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      win_cnt    <= '0;
      hp_reg     <= DIV_W'(1);
      div_cnt    <= '0;
      stim_out   <= 1'b0;
      high_count <= '0;
      edge_count <= '0;
      ovf        <= 1'b0;
    end else if (load) begin
      win_cnt    <= window;
      hp_reg     <= hp_eff;
      div_cnt    <= hp_eff - DIV_W'(1);
      stim_out   <= 1'b0;
      high_count <= '0;
      edge_count <= '0;
      ovf        <= 1'b0;
    end else if (state == RUN) begin
      if (last_cycle) begin
        stim_out <= 1'b0;
      end else if (div_cnt == '0) begin
        stim_out <= ~stim_out;
        div_cnt  <= hp_reg - DIV_W'(1);
      end else begin
        div_cnt <= div_cnt - DIV_W'(1);
      end
      if (win_cnt != '0) begin
        win_cnt <= win_cnt - CNT_W'(1);
      end
      if (count_en && cmp_s) begin
        if (&high_count) begin
          ovf <= 1'b1;
        end else begin
          high_count <= high_count + CNT_W'(1);
        end
      end
      if (count_en && rise) begin
        if (&edge_count) begin
          ovf <= 1'b1;
        end else begin
          edge_count <= edge_count + EDGE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ota_stim_measure.sv
// tb/tb_ota_stim_measure.sv - scoreboard bench for ota_stim_measure
`timescale 1ns/1ps
module tb_ota_stim_measure;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start2;
  logic [23:0] win1;
  logic [15:0] hp1;
  logic [7:0]  win2;
  logic [15:0] hp2;
  logic        cmp_lvl;
  logic        wave_slow, wave_fast;
  int          cmp_sel;
  logic        cmp_in;

  logic        so1, soe1, busy1, done1, ovf1;
  logic [23:0] hc1;
  logic [15:0] ec1;
  logic        so2, soe2, busy2, done2, ovf2;
  logic [7:0]  hc2;
  logic [1:0]  ec2;

  typedef struct {
    int   high_lo;
    int   high_hi;
    int   edge_lo;
    int   edge_hi;
    logic ovf;
    int   busy_cycles;
    int   latency;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  initial begin
    wave_slow = 1'b0;
    #3;
    forever #100 wave_slow = ~wave_slow;
  end

  initial begin
    wave_fast = 1'b0;
    #2;
    forever #15 wave_fast = ~wave_fast;
  end

  assign cmp_in = (cmp_sel == 1) ? wave_slow : (cmp_sel == 2) ? wave_fast : cmp_lvl;

  ota_stim_measure dut1 (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .start_tgl(start1), .window(win1),
    .half_period(hp1), .cmp_in(cmp_in), .stim_out(so1), .stim_oeb(soe1),
    .busy(busy1), .done(done1), .ovf(ovf1), .high_count(hc1), .edge_count(ec1)
  );

  ota_stim_measure #(.CNT_W(8), .DIV_W(16), .EDGE_W(2)) dut2 (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .start_tgl(start2), .window(win2),
    .half_period(hp2), .cmp_in(cmp_in), .stim_out(so2), .stim_oeb(soe2),
    .busy(busy2), .done(done2), .ovf(ovf2), .high_count(hc2), .edge_count(ec2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic run(input int sel, input int w, input int hp,
                     input int hlo, input int hhi, input int elo, input int ehi,
                     input logic eovf, input int mid_tgl, input string tag);
    exp_t        e;
    int          hpe;
    int          rc;
    int          bad;
    int          lat;
    logic        b, d, so, soe, ov, exp_so;
    logic [31:0] hc, ec;
    e.high_lo     = hlo;
    e.high_hi     = hhi;
    e.edge_lo     = elo;
    e.edge_hi     = ehi;
    e.ovf         = eovf;
    e.busy_cycles = (w == 0) ? 1 : w;
    e.latency     = (w == 0) ? 2 : w + 1;
    sb.push_back(e);
    hpe = (hp == 0) ? 1 : hp;
    rc  = 0;
    bad = 0;
    lat = 0;
    d   = 1'b0;
    so  = 1'b0;
    soe = 1'b0;
    @(negedge clk);
    if (sel != 0) begin
      win2   = 8'(w);
      hp2    = 16'(hp);
      start2 = ~start2;
    end else begin
      win1   = 24'(w);
      hp1    = 16'(hp);
      start1 = ~start1;
    end
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      b   = (sel != 0) ? busy2 : busy1;
      d   = (sel != 0) ? done2 : done1;
      so  = (sel != 0) ? so2 : so1;
      soe = (sel != 0) ? soe2 : soe1;
      if (mid_tgl != 0 && k == mid_tgl) begin
        if (sel != 0) start2 = ~start2;
        else start1 = ~start1;
      end
      if (b) begin
        rc++;
        exp_so = (((rc - 1) / hpe) % 2) != 0;
        if (so !== exp_so) bad++;
        if (soe !== 1'b0) bad++;
      end
      if (d) begin
        lat = k;
        break;
      end
    end
    chk({tag, " done_seen"}, 32'(d), 32'd1);
    e  = sb.pop_front();
    hc = (sel != 0) ? 32'(hc2) : 32'(hc1);
    ec = (sel != 0) ? 32'(ec2) : 32'(ec1);
    ov = (sel != 0) ? ovf2 : ovf1;
    chk({tag, " latency"}, 32'(lat), 32'(e.latency));
    chk({tag, " busy_cycles"}, 32'(rc), 32'(e.busy_cycles));
    chk({tag, " stim_pattern_errs"}, 32'(bad), 32'd0);
    chk({tag, " stim_oeb_at_done"}, 32'(soe), 32'd1);
    chk({tag, " stim_out_at_done"}, 32'(so), 32'd0);
    chk_rng({tag, " high_count"}, int'(hc), e.high_lo, e.high_hi);
    chk_rng({tag, " edge_count"}, int'(ec), e.edge_lo, e.edge_hi);
    chk({tag, " ovf"}, 32'(ov), 32'(e.ovf));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol;
    rst_n   = 1'b0;
    start1  = 1'b0;
    start2  = 1'b0;
    win1    = '0;
    hp1     = '0;
    win2    = '0;
    hp2     = '0;
    cmp_lvl = 1'b0;
    cmp_sel = 0;
    #1;
    chk("rst stim_out", 32'(so1), 32'd0);
    chk("rst stim_oeb", 32'(soe1), 32'd1);
    chk("rst busy", 32'(busy1), 32'd0);
    chk("rst done", 32'(done1), 32'd0);
    chk("rst ovf", 32'(ovf1), 32'd0);
    chk("rst high_count", 32'(hc1), 32'd0);
    chk("rst edge_count", 32'(ec1), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (soe1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) viol++;
    end
    chk("idle hold violations", 32'(viol), 32'd0);

    // Comparator high through reset; synchroniser rises on the RUN entry edge.
    @(negedge clk);
    rst_n   = 1'b0;
    cmp_lvl = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(0, 100, 5, 100, 100, 1, 1, 1'b0, 0, "w100");

    cmp_sel = 1;
    run(0, 1000, 7, 490, 510, 49, 51, 1'b0, 0, "w1000");
    cmp_sel = 0;
    cmp_lvl = 1'b0;
    repeat (5) @(negedge clk);

    run(0, 0, 0, 0, 0, 0, 0, 1'b0, 0, "w0");
    run(0, 8, 0, 0, 0, 0, 0, 1'b0, 0, "hp0");

    cmp_lvl = 1'b1;
    repeat (5) @(negedge clk);
    run(1, 255, 4, 255, 255, 0, 0, 1'b0, 0, "sat_high");
    cmp_sel = 2;
    run(1, 255, 4, 80, 175, 3, 3, 1'b1, 0, "sat_edge");
    cmp_sel = 0;
    repeat (5) @(negedge clk);

    run(0, 50, 3, 50, 50, 0, 0, 1'b0, 10, "midtgl");
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy1 !== 1'b0 || done1 !== 1'b1) viol++;
    end
    chk("midtgl no_restart violations", 32'(viol), 32'd0);

    @(negedge clk);
    win1   = 24'd200;
    hp1    = 16'd4;
    start1 = ~start1;
    repeat (20) @(negedge clk);
    chk("prerst busy", 32'(busy1), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy1), 32'd0);
    chk("midrst done", 32'(done1), 32'd0);
    chk("midrst stim_oeb", 32'(soe1), 32'd1);
    chk("midrst stim_out", 32'(so1), 32'd0);
    chk("midrst ovf", 32'(ovf1), 32'd0);
    chk("midrst high_count", 32'(hc1), 32'd0);
    chk("midrst edge_count", 32'(ec1), 32'd0);
    start1 = 1'b0;
    start2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 30, 2, 30, 30, 1, 1, 1'b0, 0, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
